// File: rtl/move_input_conditioner_if.sv
// Move request handshake between the button conditioner and the 2048 control FSM.
// master drives move_valid/move_dir, slave drives move_ready.
// move_dir codes: 00 up, 01 down, 10 left, 11 right.
interface move_input_conditioner_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;

  modport master (
    output move_valid,
    output move_dir,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_dir,
    output move_ready
  );
endinterface

// File: rtl/move_input_conditioner.sv
// Purpose: sync + debounce four direction buttons, issue one move request per press.
// Latency: clean raw press to move_valid = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: move held (dir stable) until move_ready, or dropped when i_enable falls.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_btn_raw[3:0]    raw async buttons: bit0 up, bit1 down, bit2 left, bit3 right
//   i_enable          game accepts moves
//   mv_if (master)    move_valid / move_dir out, move_ready in
//   o_btn_stable      debounced pressed levels, active-high
//   o_chord_reject    one-cycle pulse when a multi-button press is discarded
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [3:0]                 i_btn_raw,
  input  logic                       i_enable,
  move_input_conditioner_if.master   mv_if,
  output logic [3:0]                 o_btn_stable,
  output logic                       o_chord_reject
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       RELEASED = {4{BTN_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [SYNC_STAGES-1:0]      r_fill;
  logic [3:0]                  w_sync;
  logic [3:0][CNT_W-1:0]       r_cnt;
  logic [3:0]                  r_stable;
  logic                        r_primed;
  logic [1:0]                  r_dir;
  logic [1:0]                  w_dir_enc;
  logic                        w_any;
  logic                        w_one;
  logic                        w_multi;
  state_t                      r_state;
  state_t                      w_state_next;

  // Synchronizer chain, reset to the released level. r_fill tracks how far
  // real samples have propagated so the reset value is never mistaken for
  // an observed release.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync <= {SYNC_STAGES{RELEASED}};
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Normalize to pressed=1.
  assign w_sync = r_sync[SYNC_STAGES-1] ^ RELEASED;

  // Per-bit debounce: a mismatch must persist DEBOUNCE_CYCLES cycles; any
  // return to the stable level clears the count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= w_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press only counts once all buttons have really been seen released
  // since reset; buttons held through reset therefore never issue a move.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_primed <= 1'b0;
    end else if (r_fill[SYNC_STAGES-1] && (w_sync == 4'b0000)) begin
      r_primed <= 1'b1;
    end
  end

  assign w_any   = |r_stable;
  assign w_one   = w_any && ((r_stable & (r_stable - 4'd1)) == 4'd0);
  assign w_multi = w_any && !w_one;

  always_comb begin
    w_dir_enc = 2'b11;
    if (r_stable[0])      w_dir_enc = 2'b00;
    else if (r_stable[1]) w_dir_enc = 2'b01;
    else if (r_stable[2]) w_dir_enc = 2'b10;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (r_primed && w_one && i_enable) w_state_next = ISSUE;
          else                               w_state_next = HOLD;
        end
      end
      // move_valid is 1 throughout ISSUE, so move_ready alone completes it.
      ISSUE: if (mv_if.move_ready || !i_enable) w_state_next = HOLD;
      HOLD:  if (!w_any) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Direction is captured only on the IDLE->ISSUE step, so later button
  // activity cannot disturb a pending request.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_dir <= 2'b00;
    end else if ((r_state == IDLE) && (w_state_next == ISSUE)) begin
      r_dir <= w_dir_enc;
    end
  end

  // FSM outputs
  always_comb begin
    mv_if.move_valid = 1'b0;
    mv_if.move_dir   = r_dir;
    o_chord_reject   = 1'b0;
    if (r_state == ISSUE) mv_if.move_valid = 1'b1;
    if ((r_state == IDLE) && r_primed && w_multi) o_chord_reject = 1'b1;
  end

  assign o_btn_stable = r_stable;

endmodule

// File: tb/tb_move_input_conditioner.sv
module tb_move_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic       enable;
  logic [3:0] btn_stable;
  logic       chord_reject;

  int checks   = 0;
  int failures = 0;
  int n_issue  = 0;
  int n_chord  = 0;
  bit prev_valid = 1'b0;

  move_input_conditioner_if mv_if ();

  move_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_btn_raw      (btn_raw),
    .i_enable       (enable),
    .mv_if          (mv_if),
    .o_btn_stable   (btn_stable),
    .o_chord_reject (chord_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters: rising edges of move_valid and cycles of chord_reject.
  always @(negedge clk) begin
    if (mv_if.move_valid && !prev_valid) n_issue++;
    if (chord_reject) n_chord++;
    prev_valid = mv_if.move_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (mv_if.move_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int c0;
    int c1;

    rst_n = 1'b0;
    btn_raw = 4'b1111;
    enable = 1'b1;
    mv_if.move_ready = 1'b1;
    ticks(2);

    // Reset state
    chk("rst_valid",  mv_if.move_valid, 0);
    chk("rst_dir",    mv_if.move_dir,   0);
    chk("rst_stable", btn_stable,       0);
    chk("rst_chord",  chord_reject,     0);
    rst_n = 1'b1;
    ticks(5);

    // Clean left press: valid on exactly the 7th cycle, dir 10
    c0 = n_issue;
    btn_raw = 4'b1011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("clean_valid_c%0d", k), mv_if.move_valid, (k == 7) ? 1 : 0);
      if (k == 5) chk("clean_stable_c5", btn_stable, 4'b0000);
      if (k == 6) chk("clean_stable_c6", btn_stable, 4'b0100);
      if (k == 7) chk("clean_dir", mv_if.move_dir, 2'b10);
    end
    ticks(100);
    chk("hold_no_repeat", n_issue - c0, 1);
    btn_raw = 4'b1111;
    ticks(10);
    chk("release_stable", btn_stable, 0);

    // Right press
    btn_raw = 4'b0111;
    wait_valid(20, ok);
    chk("right_seen", ok, 1);
    chk("right_dir", mv_if.move_dir, 2'b11);
    ticks(15);
    btn_raw = 4'b1111;
    ticks(10);

    // Bounce on up: 2-cycle toggles for 12 cycles, then pressed
    c0 = n_issue;
    ok = 1'b1;
    for (int s = 0; s < 6; s++) begin
      btn_raw = (s % 2 == 0) ? 4'b1110 : 4'b1111;
      tick();
      if (btn_stable !== 4'b0000) ok = 1'b0;
      tick();
      if (btn_stable !== 4'b0000) ok = 1'b0;
    end
    chk("bounce_stable_quiet", ok, 1);
    btn_raw = 4'b1110;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) chk("bounce_stable_c5", btn_stable[0], 0);
      if (k == 6) chk("bounce_stable_c6", btn_stable[0], 1);
      if (k == 7) begin
        chk("bounce_valid", mv_if.move_valid, 1);
        chk("bounce_dir",   mv_if.move_dir,   2'b00);
      end
    end
    ticks(10);
    chk("bounce_one_move", n_issue - c0, 1);
    btn_raw = 4'b1111;
    ticks(10);

    // Backpressure on down, right pressed while pending
    mv_if.move_ready = 1'b0;
    btn_raw = 4'b1101;
    wait_valid(20, ok);
    chk("bp_seen", ok, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("bp_valid_%0d", i), mv_if.move_valid, 1);
      chk($sformatf("bp_dir_%0d", i),   mv_if.move_dir,   2'b01);
      if (i == 5) btn_raw = 4'b0101;
    end
    mv_if.move_ready = 1'b1;
    tick();
    chk("bp_drop", mv_if.move_valid, 0);
    btn_raw = 4'b1111;
    ticks(10);
    chk("bp_release", btn_stable, 0);

    // Chord: up + right together
    c0 = n_issue;
    c1 = n_chord;
    btn_raw = 4'b0110;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) chk("chord_c5", chord_reject, 0);
      if (k == 6) begin
        chk("chord_c6", chord_reject, 1);
        chk("chord_stable", btn_stable, 4'b1001);
      end
      if (k == 7) chk("chord_c7", chord_reject, 0);
    end
    ticks(10);
    chk("chord_pulses", n_chord - c1, 1);
    chk("chord_no_move", n_issue - c0, 0);
    btn_raw = 4'b1111;
    ticks(10);
    btn_raw = 4'b1011;
    wait_valid(20, ok);
    chk("after_chord_seen", ok, 1);
    chk("after_chord_dir", mv_if.move_dir, 2'b10);
    ticks(5);
    btn_raw = 4'b1111;
    ticks(10);

    // Enable low: press ignored
    c0 = n_issue;
    enable = 1'b0;
    btn_raw = 4'b1110;
    ticks(15);
    chk("dis_no_move", n_issue - c0, 0);
    chk("dis_stable", btn_stable, 4'b0001);
    btn_raw = 4'b1111;
    ticks(10);
    enable = 1'b1;

    // Enable dropped while pending
    mv_if.move_ready = 1'b0;
    btn_raw = 4'b1101;
    wait_valid(20, ok);
    chk("en_drop_seen", ok, 1);
    ticks(2);
    c0 = n_issue;
    enable = 1'b0;
    tick();
    chk("en_drop_clear", mv_if.move_valid, 0);
    ticks(10);
    enable = 1'b1;
    ticks(10);
    chk("en_drop_no_reissue", n_issue - c0, 0);
    btn_raw = 4'b1111;
    mv_if.move_ready = 1'b1;
    ticks(10);

    // Asynchronous reset while a move is pending
    mv_if.move_ready = 1'b0;
    btn_raw = 4'b1011;
    wait_valid(20, ok);
    chk("rst_pend_seen", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  mv_if.move_valid, 0);
    chk("arst_stable", btn_stable,       0);
    chk("arst_dir",    mv_if.move_dir,   0);
    tick();
    rst_n = 1'b1;
    c0 = n_issue;
    mv_if.move_ready = 1'b1;
    ticks(20);
    chk("held_no_move", n_issue - c0, 0);
    chk("held_stable", btn_stable, 4'b0100);
    btn_raw = 4'b1111;
    ticks(10);
    btn_raw = 4'b0111;
    wait_valid(20, ok);
    chk("post_rst_seen", ok, 1);
    chk("post_rst_dir", mv_if.move_dir, 2'b11);
    chk("post_rst_count", n_issue - c0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Upstream stage of the 2048 game control FSM. Converts four raw, bouncing direction push-buttons into one debounced move request per press.
- Each request carries a 2-bit direction code and is held under a valid/ready handshake until the control FSM accepts it.
- The accepted request is the FSM's "buttons" move event.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronized input must hold a new level before its debounced level changes (10 ms at 50 MHz); must be ≥2.
- SYNC_STAGES, 2: flip-flop stages in each button's synchronizer; must be ≥2.
- BTN_ACTIVE_LOW, 1: 1 = raw buttons read 0 when pressed; 0 = raw buttons read 1 when pressed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  4  raw buttons, asynchronous; bit0 up, bit1 down, bit2 left, bit3 right.
- enable  in  1  high while the game accepts moves (not won/lost).
- move_ready  in  1  control FSM accepts the move this cycle.
- move_valid  out  1  move request pending.
- move_dir  out  2  direction: 00 up, 01 down, 10 left, 11 right; stable while move_valid=1.
- btn_stable  out  4  debounced pressed levels, active-high (debug/LEDs).
- chord_reject  out  1  one-cycle pulse when a multi-button press is discarded.

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer flops hold the released level; counters=0; btn_stable=0000; move_valid=0; move_dir=00; chord_reject=0; FSM=IDLE. Reset asserted mid-operation drops any pending move with no acceptance.
- Synchronizer: each bit passes through SYNC_STAGES flops and is then polarity-normalized to pressed=1 (sync_i).
- Debounce, per bit:
  - If sync_i == btn_stable[i], counter_i=0.
  - Otherwise counter_i increments. When counter_i == DEBOUNCE_CYCLES-1 and the mismatch persists, btn_stable[i] takes sync_i and counter_i=0.
  - Net effect: btn_stable changes DEBOUNCE_CYCLES cycles after sync_i changes, provided there is no bounce. Any bounce back restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES); the counter never wraps.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE:
    - btn_stable=0000: stay in IDLE.
    - Exactly one bit set and enable=1: latch move_dir from that bit; next cycle in ISSUE with move_valid=1.
    - Exactly one bit set and enable=0: go to HOLD, nothing issued.
    - Two or more bits set: go to HOLD; chord_reject pulses for 1 cycle.
  - ISSUE:
    - move_valid=1 and move_dir held.
    - On move_valid & move_ready: move_valid=0 next cycle, go to HOLD.
    - If enable=0 before acceptance: move_valid=0 next cycle, go to HOLD, no move delivered.
    - Button changes in ISSUE never alter move_dir.
  - HOLD: wait for btn_stable=0000, then go to IDLE. Exactly one move per press; no auto-repeat while held.
- Latency: raw press (clean) → move_valid = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- move_ready with move_valid=0 is ignored.
- A second button pressed while the first is still held is ignored until all buttons are released.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, BTN_ACTIVE_LOW=1):
- Clean press: btn_raw 1111→1011 (left), enable=1, move_ready=1.
  - move_valid is high for exactly 1 cycle, 7 cycles after the edge, with move_dir=10.
  - Holding the button 100 cycles produces no further pulse.
  - Release then a right press gives move_dir=11.
- Bounce: up toggles 0/1 every 2 cycles for 12 cycles, then settles pressed.
  - btn_stable[0] rises exactly 4 cycles after the last synchronized edge.
  - Exactly one move_valid, with move_dir=00.
- Backpressure: down press with move_ready=0 for 20 cycles.
  - move_valid stays 1 and move_dir stays 01 throughout, including when the right button is also pressed meanwhile.
  - move_ready=1 → move_valid drops the next cycle.
- Chord: up and right pressed together (btn_raw 0110).
  - chord_reject is a 1-cycle pulse; move_valid never asserts.
  - After full release, a single left press is issued normally.
- Enable: press with enable=0 → no move. Pending move with enable dropped to 0 before move_ready → move_valid clears next cycle and is not reissued.
- Reset: assert rst=0 while move_valid=1 → outputs go to reset values immediately (asynchronously). After release with buttons still held, no move is issued until after a release and a new press.
